// File: rtl/stopwatch_display.sv
// stopwatch_display: binary centisecond count to BCD via serial double-dabble, shown on a muxed active-low 7-seg as SS.hh
//    clk    in   system clock, rising edge
//    rst    in   synchronous active-high reset
//    count  in   14-bit binary centiseconds
//    hold   in   freeze; blocks the IDLE sample while high
//    seg    out  active-low segments {g,f,e,d,c,b,a}
//    an     out  active-low digit enables, bit 0 = least significant digit
//    dp     out  active-low decimal point, lit on digit 2
//    bcd    out  displayed digits {d3,d2,d1,d0}
//    ovf    out  last converted sample exceeded 9999
//    busy   out  conversion in progress
module stopwatch_display #(
   parameter int REFRESH_DIV = 1,
   parameter bit BLANK_LZ = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] count,
   input  logic        hold,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp,
   output logic [15:0] bcd,
   output logic        ovf,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
   state_t      state_q, state_d;
   logic [13:0] bin_q, bin_d;
   logic [15:0] scr_q, scr_d, adj;
   logic [3:0]  it_q, it_d;
   logic        flag_q, flag_d;
   logic [15:0] bcd_q, bcd_d;
   logic        ovf_q, ovf_d;
   logic [15:0] ref_q, ref_d;
   logic [1:0]  d_q, d_d;
   logic [3:0]  nib;
   logic [6:0]  glyph;
   logic        wrap;
   for (genvar n = 0; n < 4; n++) begin : g_adj
      assign adj[4*n +: 4] = (scr_q[4*n +: 4] >= 4'd5) ? scr_q[4*n +: 4] + 4'd3 : scr_q[4*n +: 4];
   end
   always_comb begin
      state_d = state_q;
      bin_d = bin_q;
      scr_d = scr_q;
      it_d = it_q;
      flag_d = flag_q;
      bcd_d = bcd_q;
      ovf_d = ovf_q;
      case (state_q)
         IDLE: if (!hold) begin
            // clamping up front keeps the result within four BCD nibbles
            bin_d = (count > 14'd9999) ? 14'd9999 : count;
            flag_d = count > 14'd9999;
            scr_d = '0;
            it_d = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            scr_d = {adj[14:0], bin_q[13]};
            bin_d = {bin_q[12:0], 1'b0};
            it_d = it_q + 4'd1;
            state_d = (it_q == 4'd13) ? UPDATE : SHIFT;
         end
         UPDATE: begin
            bcd_d = scr_q;
            ovf_d = flag_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign wrap = ref_q == 16'(REFRESH_DIV - 1);
   assign ref_d = wrap ? 16'd0 : ref_q + 16'd1;
   assign d_d = wrap ? d_q + 2'd1 : d_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q <= '0;
         scr_q <= '0;
         it_q <= '0;
         flag_q <= 1'b0;
         bcd_q <= '0;
         ovf_q <= 1'b0;
         ref_q <= '0;
         d_q <= '0;
      end else begin
         state_q <= state_d;
         bin_q <= bin_d;
         scr_q <= scr_d;
         it_q <= it_d;
         flag_q <= flag_d;
         bcd_q <= bcd_d;
         ovf_q <= ovf_d;
         ref_q <= ref_d;
         d_q <= d_d;
      end
   end
   assign nib = bcd_q[{d_q, 2'b00} +: 4];
   always_comb begin
      glyph = 7'b0111111;
      case (nib)
         4'd0: glyph = 7'b1000000;
         4'd1: glyph = 7'b1111001;
         4'd2: glyph = 7'b0100100;
         4'd3: glyph = 7'b0110000;
         4'd4: glyph = 7'b0011001;
         4'd5: glyph = 7'b0010010;
         4'd6: glyph = 7'b0000010;
         4'd7: glyph = 7'b1111000;
         4'd8: glyph = 7'b0000000;
         4'd9: glyph = 7'b0010000;
         default: glyph = 7'b0111111;
      endcase
   end
   assign seg = (BLANK_LZ && d_q == 2'd3 && nib == 4'd0) ? 7'b1111111 : glyph;
   assign an = ~(4'b0001 << d_q);
   assign dp = d_q != 2'd2;
   assign bcd = bcd_q;
   assign ovf = ovf_q;
   assign busy = state_q != IDLE;
endmodule
